// File: rtl/rr_mux_pipe.sv
// ---------------------------------------------------------------------------
// rr_mux_pipe
//   N-input, WIDTH-bit registered multiplexer / arbiter. Each input and the
//   output use a valid/ready handshake. The block adds one register stage.
//   There are two selection modes:
//     mode=0 : fixed select. The channel is named by `select`. An
//              out-of-range select never grants.
//     mode=1 : round-robin. The search starts at rr_ptr+1 and wraps.
//
//   Optional build macro: ARB_LOCK_EN
//     When it is defined, a round-robin grant taken with lock=1 pins the
//     arbiter to that channel. The pin lasts until that channel transfers
//     with lock=0. When it is undefined, the lock port is ignored.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   mode       0 = fixed select, 1 = round-robin
//   select     channel index used in fixed mode
//   in_data    flattened inputs, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, one-hot or zero)
//   out_data   registered output data
//   out_valid  registered output valid
//   out_ready  consumer ready
//   out_sel    registered index of the channel behind out_data
//   lock       burst lock request (only meaningful with ARB_LOCK_EN)
// ---------------------------------------------------------------------------

// Per-channel eligibility: decides whether channel IDX may win this cycle.
module rr_mux_lane #(
    parameter int SEL_W = 2,
    parameter int IDX   = 0
) (
    input  logic             mode,
    input  logic [SEL_W-1:0] select,
    input  logic             valid,
    input  logic             lock_ok,
    output logic             elig
);
    always_comb begin
        if (mode)
            elig = valid && lock_ok;
        else
            elig = valid && (select == SEL_W'(IDX));
    end
endmodule

module rr_mux_pipe #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        select,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    lock
);
    localparam int STAGES = 1;

    // vld_pipe[0] is the combinational "a word is accepted this cycle" bit.
    // vld_pipe[STAGES] is the registered output valid.
    logic [STAGES:0]                  vld_pipe;
    logic [NUM_IN-1:0][WIDTH-1:0]     din;
    logic [NUM_IN-1:0]                elig;
    logic [NUM_IN-1:0]                lock_ok;
    logic [NUM_IN-1:0]                grant;
    logic [SEL_W-1:0]                 rr_ptr;
    logic [SEL_W-1:0]                 gidx;
    logic [WIDTH-1:0]                 gdata;
    logic                             load;
    logic                             found;
    logic                             gany;

    // The packed array uses the same layout as the flattened input bus.
    assign din       = in_data;
    assign out_valid = vld_pipe[STAGES];

    // The output register is a single full-throughput stage.
    assign load = !out_valid || out_ready;

`ifdef ARB_LOCK_EN
    logic             lock_active;
    logic [SEL_W-1:0] lock_ch;

    always_comb begin
        for (int j = 0; j < NUM_IN; j++)
            lock_ok[j] = !lock_active || (lock_ch == SEL_W'(j));
    end

    // Lock only changes on an accepted round-robin word. While the lock is
    // held, only lock_ch can be granted. So "the first transfer from lock_ch
    // with lock=0" is just the next accepted word with lock=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_active <= 1'b0;
            lock_ch     <= '0;
        end else if (gany && mode) begin
            lock_active <= lock;
            if (lock)
                lock_ch <= gidx;
        end
    end
`else
    wire unused_lock = lock;
    assign lock_ok = '1;
`endif

    for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
        rr_mux_lane #(
            .SEL_W (SEL_W),
            .IDX   (i)
        ) u_lane (
            .mode    (mode),
            .select  (select),
            .valid   (in_valid[i]),
            .lock_ok (lock_ok[i]),
            .elig    (elig[i])
        );
    end

    // Rotating priority without a modulo. First take the lowest eligible
    // channel above rr_ptr. Failing that, take the lowest one at or below it.
    // In fixed mode at most one channel is eligible, so the same search
    // serves both modes.
    always_comb begin
        logic             hi_f, lo_f;
        logic [SEL_W-1:0] hi_i, lo_i;
        hi_f = 1'b0;
        lo_f = 1'b0;
        hi_i = '0;
        lo_i = '0;
        for (int j = 0; j < NUM_IN; j++) begin
            if (!hi_f && elig[j] && (SEL_W'(j) > rr_ptr)) begin
                hi_f = 1'b1;
                hi_i = SEL_W'(j);
            end
            if (!lo_f && elig[j] && (SEL_W'(j) <= rr_ptr)) begin
                lo_f = 1'b1;
                lo_i = SEL_W'(j);
            end
        end
        found = hi_f || lo_f;
        gidx  = hi_f ? hi_i : lo_i;
    end

    // No grant while stalled or held in reset.
    assign gany        = found && load && !rst;
    assign vld_pipe[0] = gany;

    always_comb begin
        grant = '0;
        for (int j = 0; j < NUM_IN; j++)
            grant[j] = gany && (gidx == SEL_W'(j));
    end

    assign in_ready = grant;

    always_comb begin
        gdata = '0;
        for (int j = 0; j < NUM_IN; j++)
            if (grant[j])
                gdata = din[j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[STAGES:1] <= '0;
            out_data           <= '0;
            out_sel            <= '0;
            rr_ptr             <= SEL_W'(NUM_IN - 1);
        end else if (load) begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (gany) begin
                out_data <= gdata;
                out_sel  <= gidx;
                if (mode)
                    rr_ptr <= gidx;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux_pipe.sv
module tb_rr_mux_pipe;
    localparam int WIDTH  = 5;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] s;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    mode;
    logic [SEL_W-1:0]        select;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_sel;
    logic                    lock;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    rr_mux_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .select    (select),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .lock      (lock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_push(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s);
        exp_t e;
        e.d = d;
        e.s = s;
        sb_q.push_back(e);
    endtask

    task automatic set_data(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                            input logic [WIDTH-1:0] d2);
        in_data = {d2, d1, d0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a word leaves on the next rising edge when valid&&ready is
    // seen here.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got data 0x%0h sel %0d with nothing expected",
                             out_data, out_sel);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_data", 32'(out_data), 32'(e.d));
                    chk("sb_sel", 32'(out_sel), 32'(e.s));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [SEL_W-1:0] lock_exp [5];

    initial begin
`ifdef ARB_LOCK_EN
        lock_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
`else
        lock_exp = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
`endif
        // Reset and idle checks.
        rst = 1'b1;
        mode = 1'b1;
        select = '0;
        lock = 1'b0;
        out_ready = 1'b1;
        in_valid = 3'b111;
        set_data(5'h01, 5'h02, 5'h03);
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_sel", 32'(out_sel), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        step();
        step();
        rst = 1'b0;
        in_valid = '0;
        step();
        step();
        chk("idle_out_valid", 32'(out_valid), 0);

        // Reset mid-transfer. A held word is discarded asynchronously.
        out_ready = 1'b0;
        set_data(5'h15, 5'h02, 5'h03);
        in_valid = 3'b001;
        step();
        chk("mid_pre_valid", 32'(out_valid), 1);
        chk("mid_pre_data", 32'(out_data), 32'h15);
        in_valid = 3'b111;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        chk("mid_rst_ready", 32'(in_ready), 0);
        in_valid = '0;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();

        // Fixed select.
        mode = 1'b0;
        select = 2'd1;
        set_data(5'h11, 5'h0A, 5'h1C);
        in_valid = 3'b111;
        sb_push(5'h0A, 2'd1);
        #1 chk("fix_ready_sel1", 32'(in_ready), 32'b010);
        step();
        select = 2'd3;
        #1 chk("fix_ready_sel3", 32'(in_ready), 0);
        step();
        chk("fix_sel3_valid", 32'(out_valid), 0);
        select = 2'd0;
        in_valid = 3'b110;
        #1 chk("fix_ready_novalid", 32'(in_ready), 0);
        in_valid = '0;
        step();

        // Round-robin with all three channels requesting.
        mode = 1'b1;
        set_data(5'h01, 5'h02, 5'h03);
        in_valid = 3'b111;
        for (int k = 0; k < 8; k++) begin
            sb_push(WIDTH'(k % 3 + 1), SEL_W'(k % 3));
            #1 chk("rr_ready", 32'(in_ready), 32'(1 << (k % 3)));
            @(posedge clk);
            #1;
        end

        // Back-pressure. 0x02 from ch1 stays in the output register.
        out_ready = 1'b0;
        #1;
        chk("bp_ready", 32'(in_ready), 0);
        chk("bp_data", 32'(out_data), 32'h02);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_hold_ready", 32'(in_ready), 0);
            chk("bp_hold_data", 32'(out_data), 32'h02);
            chk("bp_hold_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        sb_push(5'h03, 2'd2);
        #1 chk("bp_release_ready", 32'(in_ready), 32'b100);
        step();

        // Sparse requests with wrap. rr_ptr is 2 here.
        set_data(5'h01, 5'h02, 5'h1E);
        in_valid = 3'b100;
        sb_push(5'h1E, 2'd2);
        #1 chk("sp_ready_ch2", 32'(in_ready), 32'b100);
        step();
        in_valid = 3'b010;
        sb_push(5'h02, 2'd1);
        #1 chk("sp_ready_ch1", 32'(in_ready), 32'b010);
        step();
        in_valid = 3'b001;
        sb_push(5'h01, 2'd0);
        #1 chk("sp_ready_ch0", 32'(in_ready), 32'b001);
        step();
        in_valid = '0;
        #1 chk("sp_ready_none", 32'(in_ready), 0);
        step();
        chk("sp_drain_valid", 32'(out_valid), 0);

        // Lock burst. Reset first so channel 0 has first priority.
        rst = 1'b1;
        step();
        rst = 1'b0;
        mode = 1'b1;
        set_data(5'h05, 5'h06, 5'h07);
        in_valid = 3'b011;
        for (int k = 0; k < 5; k++) begin
            lock = (k < 3);
            sb_push((lock_exp[k] == 2'd1) ? 5'h06 : 5'h05, lock_exp[k]);
            #1 chk("lock_ready", 32'(in_ready), 32'(1 << lock_exp[k]));
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        lock = 1'b0;
        step();
        step();
        chk("final_valid", 32'(out_valid), 0);
        chk("sb_empty", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rr_mux_pipe.md
Name: rr_mux_pipe

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer/arbiter with a valid/ready handshake on every input and on the output.
- Two modes:
  - Fixed mode: the input is chosen by an explicit select, as in the existing datapath muxes.
  - Round-robin mode: the block arbitrates fairly among requesting inputs.
- Sits between multiple producers (forwarding paths, writeback sources, memory responses) and a single consumer stage, adding one register stage.

Parameters:
- WIDTH, 5, data width of each input and of the output.
- NUM_IN, 3, number of input channels (2..16).
- SEL_W, 2, width of select and grant-index signals; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- select  input  SEL_W  channel index used in fixed mode.
- in_data  input  NUM_IN*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready, combinational; at most one bit high.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_sel  output  SEL_W  registered index of the channel that produced out_data.
- lock  input  1  burst lock request; used only when ARB_LOCK_EN is defined.

Behaviour:
- Reset, asynchronous, effective immediately on assertion:
  - out_data=0, out_valid=0, out_sel=0.
  - rr_ptr=NUM_IN-1, so channel 0 has first priority after reset.
  - lock_active=0.
  - in_ready is all zeros while rst is high.
- Load condition: load = !out_valid || out_ready. The output register is a single full-throughput stage.
- Grant, combinational:
  - grant = 0 when load is 0.
  - Fixed mode: grant channel select if select < NUM_IN and in_valid[select]=1. Otherwise no grant; an out-of-range select never grants.
  - Round-robin mode: grant the first channel with in_valid set, searching (rr_ptr+1)..(rr_ptr+NUM_IN) modulo NUM_IN.
- in_ready[i] = grant[i]. A transfer on input i occurs when in_valid[i] and in_ready[i] are both high.
- Clock edge when load=1:
  - If a grant exists: out_data <= granted in_data, out_sel <= granted index, out_valid <= 1. In round-robin mode only, rr_ptr <= granted index.
  - If no grant exists: out_valid <= 0, and out_data/out_sel hold their last values.
- Clock edge when load=0: output registers hold and rr_ptr holds. Data is never dropped or duplicated.
- Latency: exactly 1 cycle from input transfer to out_valid. Sustains one word per cycle while out_ready=1.
- Back-pressure: while out_valid=1 and out_ready=0, no in_ready is asserted and out_data is stable.
- Mode or select changes take effect on the next grant computation. An accepted word is not affected.
- rr_ptr wrap: after granting channel NUM_IN-1, the search restarts at channel 0.
- Simultaneous requests in round-robin mode: each requesting channel is served within NUM_IN consecutive grants; no starvation.
- Reset mid-transfer: the word held in the output register is discarded and out_valid drops asynchronously.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - In round-robin mode, a grant taken with lock=1 sets lock_active=1 and lock_ch=granted index.
  - While lock_active=1, only lock_ch may be granted; other channels get no grant even if valid.
  - lock_active clears on the first transfer from lock_ch with lock=0. That transfer completes normally and rr_ptr advances.
  - Reset clears lock_active.
  - Fixed mode ignores lock entirely.
- Undefined: the lock port is present but ignored, lock_active is absent, and arbitration is plain round-robin.

Test Plan:
- Reset/idle: assert rst mid-cycle with out_valid=1 -> out_valid=0, out_data=0, in_ready=0 immediately; after release with in_valid=0 -> out_valid remains 0.
- Fixed select: mode=0, select=1, in_valid=3'b111, ch1=5'h0A, out_ready=1 -> next cycle out_data=0x0A, out_sel=1; then select=3 -> no in_ready, out_valid=0 the following cycle.
- Round-robin fairness: mode=1, all three valid continuously, data ch0/1/2=0x01/0x02/0x03, out_ready=1 -> out_sel sequence 0,1,2,0,1,2; out_data 0x01,0x02,0x03 repeating.
- Back-pressure: out_ready=0 for 4 cycles with out_valid=1, out_data=0x02 -> out_data stable, in_ready=0, rr_ptr unchanged; out_ready=1 -> next grant goes to channel 2.
- Sparse requests/wrap: mode=1, rr_ptr=2, only ch2 valid -> ch2 granted (search wraps 0,1,2), out_sel=2.
- ARB_LOCK_EN: mode=1, ch0 valid with lock=1 for 3 transfers, ch1 valid throughout -> out_sel=0,0,0; then lock=0 on the 4th ch0 transfer -> next grant is ch1. Without the macro -> alternating 0,1,0,1.
